// File: rtl/audio_i2s_serializer_if.sv
// Bundle between the audio mixer side and the I2S serializer.
// Carries samples/controls in and I2S clocks/data/status out.
interface audio_i2s_serializer_if;
  logic [15:0] audio_in_left;
  logic [15:0] audio_in_right;
  logic [3:0]  vol_atten;
  logic        mute;
  logic        audio_mclk;
  logic        audio_lrck;
  logic        audio_sck;
  logic        audio_sdin;
  logic        sample_req;
  logic        muted;

  modport master (
    output audio_in_left, audio_in_right, vol_atten, mute,
    input  audio_mclk, audio_lrck, audio_sck, audio_sdin,
    input  sample_req, muted
  );

  modport slave (
    input  audio_in_left, audio_in_right, vol_atten, mute,
    output audio_mclk, audio_lrck, audio_sck, audio_sdin,
    output sample_req, muted
  );
endinterface

// File: rtl/audio_i2s_serializer.sv
// Stereo I2S serializer, 512-clk frame, 16 bits/channel, with
// static attenuation and frame-stepped soft-mute ramp.
// Ports: clk, rst (async, active high), bus (slave modport):
//   in  audio_in_left/right[15:0], vol_atten[3:0], mute
//   out audio_mclk, audio_lrck, audio_sck, audio_sdin,
//       sample_req, muted
// Define AUDIO_SER_MONO_EN to send the left sample on both channels.
module audio_i2s_serializer (
  input  logic                    clk,
  input  logic                    rst,
  audio_i2s_serializer_if.slave   bus
);

  typedef enum logic [1:0] {
    PLAY,
    RAMP_DOWN,
    MUTED,
    RAMP_UP
  } state_t;

  state_t      state, state_n;
  logic [4:0]  r, r_n;
  logic [8:0]  cnt, cnt_n;
  logic        latch;
  logic [4:0]  tot;
  logic [15:0] hold_l, hold_r;
  logic [3:0]  bit_idx;
  logic        bit_n;
  logic        muted_c;

  logic mclk_q, sck_q, lrck_q, sdin_q, req_q;

  assign cnt_n = cnt + 9'd1;
  assign latch = (cnt == 9'd0);

  function automatic logic [15:0] atten(
    input logic [15:0] s,
    input logic [4:0]  t
  );
    logic signed [15:0] v;
    v = $signed(s) >>> t[3:0];
    return t[4] ? 16'h0000 : v;
  endfunction

  // new r takes effect on the sample latched at the same edge
  assign tot = {1'b0, bus.vol_atten} + r_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= PLAY;
      r     <= 5'd0;
    end else if (latch) begin
      state <= state_n;
      r     <= r_n;
    end
  end

  always_comb begin
    state_n = state;
    r_n     = r;
    unique case (state)
      PLAY: begin
        r_n = 5'd0;
        if (bus.mute) begin
          state_n = RAMP_DOWN;
          r_n     = 5'd1;
        end
      end
      RAMP_DOWN: begin
        if (!bus.mute) begin
          r_n     = r - 5'd1;
          state_n = (r == 5'd1) ? PLAY : RAMP_UP;
        end else begin
          r_n = r + 5'd1;
          if (r == 5'd15) state_n = MUTED;
        end
      end
      MUTED: begin
        r_n = 5'd16;
        if (!bus.mute) begin
          state_n = RAMP_UP;
          r_n     = 5'd15;
        end
      end
      RAMP_UP: begin
        if (bus.mute) begin
          r_n     = r + 5'd1;
          state_n = (r == 5'd15) ? MUTED : RAMP_DOWN;
        end else begin
          r_n = r - 5'd1;
          if (r == 5'd1) state_n = PLAY;
        end
      end
    endcase
  end

  always_comb begin
    muted_c = (state == MUTED);
  end

  // Loaded at the end of period p for period p+1: channel is
  // cnt[8] and bit index works out to ~p[3:0] for both halves.
  assign bit_idx = ~cnt[7:4];
  assign bit_n   = cnt[8] ? hold_r[bit_idx] : hold_l[bit_idx];

`ifdef AUDIO_SER_MONO_EN
  logic unused_right;
  assign unused_right = ^bus.audio_in_right;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= 9'd0;
      mclk_q <= 1'b0;
      sck_q  <= 1'b0;
      lrck_q <= 1'b0;
      sdin_q <= 1'b0;
      req_q  <= 1'b0;
      hold_l <= 16'h0000;
      hold_r <= 16'h0000;
    end else begin
      cnt    <= cnt_n;
      mclk_q <= cnt_n[1];
      sck_q  <= cnt_n[3];
      lrck_q <= cnt_n[8];
      req_q  <= (cnt_n == 9'd511);
      if (cnt[3:0] == 4'hF) sdin_q <= bit_n;
      if (latch) begin
        hold_l <= atten(bus.audio_in_left, tot);
`ifdef AUDIO_SER_MONO_EN
        hold_r <= atten(bus.audio_in_left, tot);
`else
        hold_r <= atten(bus.audio_in_right, tot);
`endif
      end
    end
  end

  assign bus.audio_mclk = mclk_q;
  assign bus.audio_sck  = sck_q;
  assign bus.audio_lrck = lrck_q;
  assign bus.audio_sdin = sdin_q;
  assign bus.sample_req = req_q;
  assign bus.muted      = muted_c;

endmodule

// File: tb/tb_audio_i2s_serializer.sv
// Directed bench for audio_i2s_serializer: frame words are
// collected off audio_sdin and checked against a scoreboard.
module tb_audio_i2s_serializer;

  logic clk = 1'b0;
  logic rst;

  audio_i2s_serializer_if bus ();

  audio_i2s_serializer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    logic        m;
  } exp_t;

  exp_t exp_q[$];

  logic [8:0] tcnt;
  always @(posedge clk or posedge rst) begin
    if (rst) tcnt <= 9'd0;
    else     tcnt <= tcnt + 9'd1;
  end

  task automatic chk(
    input string       tag,
    input logic [15:0] obs,
    input logic [15:0] ex
  );
    checks++;
    assert (obs === ex) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, ex);
    end
  endtask

  function automatic logic [15:0] att(
    input logic [15:0] s,
    input int          sh
  );
    logic signed [15:0] t;
    t = s;
    if (sh >= 16) return 16'h0000;
    return t >>> sh;
  endfunction

  task automatic push_exp(
    input logic [15:0] l,
    input logic [15:0] rr,
    input logic [3:0]  va,
    input int          er,
    input logic        em
  );
    exp_t e;
    e.l = att(l, int'(va) + er);
`ifdef AUDIO_SER_MONO_EN
    e.r = att(l, int'(va) + er);
`else
    e.r = att(rr, int'(va) + er);
`endif
    e.m = em;
    exp_q.push_back(e);
  endtask

  // Drive inputs for the next latch and record what it must yield.
  task automatic do_frame(
    input logic [15:0] l,
    input logic [15:0] rr,
    input logic [3:0]  va,
    input logic        m,
    input int          er,
    input logic        em
  );
    int n;
    n = 0;
    while (tcnt != 9'd511 && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (tcnt != 9'd511) chk("frame_wait", {7'd0, tcnt}, 16'd511);
    chk("sample_req_hi", {15'd0, bus.sample_req}, 16'd1);
    bus.audio_in_left  = l;
    bus.audio_in_right = rr;
    bus.vol_atten      = va;
    bus.mute           = m;
    push_exp(l, rr, va, er, em);
    @(negedge clk);
  endtask

  logic [15:0] obs_l, obs_r;
  logic        obs_m;
  bit          have_left = 0;
  int          mp;
  exp_t        pe;

  always @(negedge clk) begin
    if (rst) begin
      have_left = 0;
    end else if (tcnt[3:0] == 4'h8) begin
      mp = int'(tcnt[8:4]);
      if (mp == 1) begin
        have_left = 1;
        obs_m = bus.muted;
      end
      if (mp >= 1 && mp <= 16) begin
        obs_l[16-mp] = bus.audio_sdin;
      end else if (mp >= 17) begin
        obs_r[32-mp] = bus.audio_sdin;
      end else if (have_left) begin
        obs_r[0] = bus.audio_sdin;
        have_left = 0;
        if (exp_q.size() == 0) begin
          chk("sb_underflow", 16'd1, 16'd0);
        end else begin
          pe = exp_q.pop_front();
          chk("left_word", obs_l, pe.l);
          chk("right_word", obs_r, pe.r);
          chk("muted", {15'd0, obs_m}, {15'd0, pe.m});
        end
      end
    end
  end

  initial begin
    int e_mclk, e_sck, e_lrck, e_req, n_req, n;
    e_mclk = 0;
    e_sck  = 0;
    e_lrck = 0;
    e_req  = 0;
    n_req  = 0;

    rst = 1'b1;
    bus.audio_in_left  = 16'h8001;
    bus.audio_in_right = 16'h4002;
    bus.vol_atten      = 4'd0;
    bus.mute           = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_mclk", {15'd0, bus.audio_mclk}, 16'd0);
    chk("rst_sck", {15'd0, bus.audio_sck}, 16'd0);
    chk("rst_lrck", {15'd0, bus.audio_lrck}, 16'd0);
    chk("rst_sdin", {15'd0, bus.audio_sdin}, 16'd0);
    chk("rst_req", {15'd0, bus.sample_req}, 16'd0);
    chk("rst_muted", {15'd0, bus.muted}, 16'd0);

    push_exp(16'h8001, 16'h4002, 4'd0, 0, 1'b0);
    push_exp(16'h8001, 16'h4002, 4'd0, 0, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 1024; i++) begin
      if (bus.audio_mclk !== tcnt[1]) e_mclk++;
      if (bus.audio_sck !== tcnt[3]) e_sck++;
      if (bus.audio_lrck !== tcnt[8]) e_lrck++;
      if (bus.sample_req !== (tcnt == 9'd511)) e_req++;
      if (bus.sample_req === 1'b1) n_req++;
      if (i < 1023) @(negedge clk);
    end
    chk("mclk_wave", 16'(e_mclk), 16'd0);
    chk("sck_wave", 16'(e_sck), 16'd0);
    chk("lrck_wave", 16'(e_lrck), 16'd0);
    chk("req_wave", 16'(e_req), 16'd0);
    chk("req_pulses", 16'(n_req), 16'd2);

    do_frame(16'h8000, 16'h1234, 4'd3, 1'b0, 0, 1'b0);
    do_frame(16'h8000, 16'h8000, 4'd15, 1'b0, 0, 1'b0);
    do_frame(16'h8000, 16'h7FFF, 4'd15, 1'b1, 1, 1'b0);
    do_frame(16'h7FFF, 16'h8001, 4'd0, 1'b0, 0, 1'b0);
    do_frame(16'h7FFF, 16'h8001, 4'd0, 1'b0, 0, 1'b0);

    for (int k = 1; k <= 16; k++)
      do_frame(16'h7FFF, 16'h8001, 4'd0, 1'b1, k, k == 16);
    do_frame(16'h7FFF, 16'h8001, 4'd0, 1'b1, 16, 1'b1);
    for (int j = 1; j <= 16; j++)
      do_frame(16'h7FFF, 16'h8001, 4'd0, 1'b0, 16 - j, 1'b0);

    for (int k = 1; k <= 5; k++)
      do_frame(16'h7FFF, 16'hC3A5, 4'd0, 1'b1, k, 1'b0);
    for (int k = 4; k >= 0; k--)
      do_frame(16'h7FFF, 16'hC3A5, 4'd0, 1'b0, k, 1'b0);
    do_frame(16'h7FFF, 16'hC3A5, 4'd0, 1'b0, 0, 1'b0);

    for (int k = 1; k <= 16; k++)
      do_frame(16'h5A5A, 16'hA5A5, 4'd0, 1'b1, k, k == 16);
    do_frame(16'h5A5A, 16'hA5A5, 4'd0, 1'b1, 16, 1'b1);

    n = 0;
    while (tcnt != 9'd300 && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (tcnt != 9'd300) chk("wait_300", {7'd0, tcnt}, 16'd300);
    rst = 1'b1;
    #1;
    chk("arst_mclk", {15'd0, bus.audio_mclk}, 16'd0);
    chk("arst_sck", {15'd0, bus.audio_sck}, 16'd0);
    chk("arst_lrck", {15'd0, bus.audio_lrck}, 16'd0);
    chk("arst_sdin", {15'd0, bus.audio_sdin}, 16'd0);
    chk("arst_req", {15'd0, bus.sample_req}, 16'd0);
    chk("arst_muted", {15'd0, bus.muted}, 16'd0);
    exp_q.delete();

    bus.audio_in_left  = 16'h1234;
    bus.audio_in_right = 16'hABCD;
    bus.vol_atten      = 4'd0;
    bus.mute           = 1'b0;
    push_exp(16'h1234, 16'hABCD, 4'd0, 0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    do_frame(16'h00FF, 16'hFF00, 4'd4, 1'b0, 0, 1'b0);

    n = 0;
    while (exp_q.size() != 0 && n < 1200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 16'(exp_q.size()), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
